// File: rtl/serial_subtractor_pkg.sv
// Shared types and the one-bit borrow arithmetic for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

  // Returns {borrow_out, difference} for a single bit position.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bw);
    full_sub = {(~a & b) | (~(a ^ b) & bw), a ^ b ^ bw};
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor_bit.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor_bit
  import serial_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign {bout, d} = full_sub(a, b, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: out = in1 - in2 as a (WIDTH+1)-bit two's-complement value,
// one bit per clock, LSB first, with a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_sh_next;
  logic [CNT_W-1:0] count;
  logic             borrow;
  logic             d_bit;
  logic             bw_next;
  logic             start_ok;

  // An X/Z start must not launch an operation, so only a clean 1 counts.
  assign start_ok    = (start === 1'b1);
  assign busy        = (state == SHIFT);
  assign res_sh_next = {d_bit, res_sh[WIDTH-1:1]};

  full_subtractor_bit u_bit (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (bw_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      count  <= '0;
      out    <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start_ok) begin
            a_sh   <= in1;
            b_sh   <= in2;
            res_sh <= '0;
            borrow <= 1'b0;
            count  <= '0;
            state  <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_sh_next;
          borrow <= bw_next;
          count  <= count + CNT_W'(1);
          // The result is published only once, complete, on the final bit.
          if (count == LAST_CNT) begin
            out   <= {bw_next, res_sh_next};
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operations against
// a plain-arithmetic reference model.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       busy;
  logic       done;
  logic [8:0] out;

  int checks;
  int failures;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Runs one operation starting at the current negedge and returns at the done negedge.
  // glitch_at >= 2 re-asserts start with fresh operands during SHIFT; it must be ignored.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int glitch_at,
                               input string tag);
    logic [8:0] exp_out;
    logic [8:0] prev_out;
    int         latency;
    int         busy_count;
    bit         hold_ok;
    exp_out    = 9'({1'b0, a} - {1'b0, b});
    prev_out   = out;
    hold_ok    = 1'b1;
    latency    = 0;
    busy_count = 0;
    in1   = a;
    in2   = b;
    start = 1'b1;
    for (int n = 1; n <= 20 && latency == 0; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == glitch_at) begin
        start = 1'b1;
        in1   = 8'($urandom);
        in2   = 8'($urandom);
      end else if (n == glitch_at + 1) begin
        start = 1'b0;
      end
      if (busy) busy_count++;
      if (done) latency = n;
      else if (out !== prev_out) hold_ok = 1'b0;
    end
    checkOutput({tag, ".latency"}, latency, 9);
    checkOutput({tag, ".busy_cycles"}, busy_count, 8);
    checkOutput({tag, ".out"}, out, exp_out);
    checkOutput({tag, ".sign"}, out[8], (a < b) ? 1 : 0);
    checkOutput({tag, ".hold"}, hold_ok, 1);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [8:0] sum;
    bit         done_seen;
    bit         busy_seen;

    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    start    = 1'bx;
    in1      = 8'h00;
    in2      = 8'h00;

    // Reset held: a start pulse must not disturb anything.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b1;
      if (i == 2) start = 1'b0;
      checkOutput("reset.busy", busy, 0);
      checkOutput("reset.done", done, 0);
      checkOutput("reset.out", out, 0);
    end
    rst   = 1'b1;
    start = 1'bx;
    busy_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    checkOutput("xstart.busy", busy_seen, 0);
    start = 1'b0;
    @(negedge clk);

    applyStimulus(8'hA5, 8'h0F, 0, "basic");
    @(negedge clk);
    applyStimulus(8'h6F, 8'hC5, 0, "b2b_first");
    applyStimulus(8'hAF, 8'hCF, 0, "b2b_second");
    @(negedge clk);
    applyStimulus(8'h00, 8'hFF, 0, "zero_minus_max");
    applyStimulus(8'hFF, 8'h00, 0, "max_minus_zero");
    applyStimulus(8'h5A, 8'h5A, 0, "equal");
    @(negedge clk);
    applyStimulus(8'hA5, 8'h0F, 2, "start_during_shift");
    @(negedge clk);

    // Abort mid-operation with an asynchronous reset between edges.
    in1   = 8'h33;
    in2   = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort.busy", busy, 0);
    checkOutput("abort.done", done, 0);
    checkOutput("abort.out", out, 0);
    @(negedge clk);
    rst = 1'b1;
    done_seen = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
    checkOutput("abort.no_done", done_seen, 0);
    checkOutput("abort.no_busy", busy_seen, 0);
    applyStimulus(8'h33, 8'h11, 0, "after_abort");

    // Random operations with random idle gaps (zero gap = back-to-back).
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(8'($urandom), 8'($urandom), 0, "random");
    end

    // Adder round trip: ((a + b) mod 256) - b recovers a; no borrow when the sum fits.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ra  = 8'($urandom);
      rb  = 8'($urandom_range(0, 255 - int'(ra)));
      sum = {1'b0, ra} + {1'b0, rb};
      applyStimulus(sum[7:0], rb, 0, "cross");
      checkOutput("cross.recover", out, {1'b0, ra});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
